// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl
//   Time-multiplexes two hex digits onto one shared seven-segment decoder.
//   Each digit is lit for PERIOD cycles. An optional blanking interval of DEAD
//   cycles precedes each digit, so the decoder can settle with all anodes off.
//   New digit pairs arrive through a valid/ready handshake into a shadow
//   register. They reach the display only at a frame boundary, so a frame
//   never shows a mix of old and new data.
//
//   Build option: define SEVSEG_DEADTIME_EN to enable the blanking states.
//   When it is undefined the scan is SHOW0 -> SHOW1 and the DEAD parameter
//   has no effect.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous, active-high
//   load_valid  in   din holds a new digit pair
//   load_ready  out  shadow register is free (no pending pair)
//   din[7:0]    in   [3:0] digit 0, [7:4] digit 1
//   s[3:0]      out  nibble for the shared decoder
//   an_n[1:0]   out  active-low digit enables (bit0 = digit 0)
//   frame_tick  out  high in the last cycle of every frame
//
// State table
//   state  | meaning
//   BLANK0 | anodes off, decoder fed digit 0 (dead-time build only)
//   SHOW0  | digit 0 lit
//   BLANK1 | anodes off, decoder fed digit 1 (dead-time build only)
//   SHOW1  | digit 1 lit; the frame ends in its last cycle

module seven_seg_scan_ctrl #(
  parameter int PERIOD = 24000,
  parameter int DEAD   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_valid,
  output logic       load_ready,
  input  logic [7:0] din,
  output logic [3:0] s,
  output logic [1:0] an_n,
  output logic       frame_tick
);

  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] SHOW_TC = CW'(PERIOD - 1);
  localparam logic [CW-1:0] DEAD_TC = CW'(DEAD - 1);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

`ifdef SEVSEG_DEADTIME_EN
  localparam state_t RESET_STATE = BLANK0;
`else
  localparam state_t RESET_STATE = SHOW0;
`endif

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   tc;
  logic            at_tc;
  logic            in_blank;
  logic            digit1;
  logic [7:0]      active;
  logic [7:0]      shadow;
  logic            pending;
  logic            transfer;
  logic            commit;

  // The blank states are unreachable when dead time is disabled, so the
  // DEAD terminal count only ever takes effect in the dead-time build.
  assign in_blank = (state == BLANK0) || (state == BLANK1);
  assign tc       = in_blank ? DEAD_TC : SHOW_TC;
  assign at_tc    = (cnt == tc);
  assign digit1   = (state == BLANK1) || (state == SHOW1);

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (at_tc) begin
      unique case (state)
`ifdef SEVSEG_DEADTIME_EN
        BLANK0:  state_next = SHOW0;
        SHOW0:   state_next = BLANK1;
        BLANK1:  state_next = SHOW1;
        SHOW1:   state_next = BLANK0;
`else
        SHOW0:   state_next = SHOW1;
        SHOW1:   state_next = SHOW0;
        default: state_next = SHOW0;
`endif
      endcase
    end
  end

  // Output decode. It uses registered state only.
  always_comb begin
    an_n = 2'b11;
    unique case (state)
      SHOW0:   an_n = 2'b10;
      SHOW1:   an_n = 2'b01;
      default: an_n = 2'b11;
    endcase
  end

  assign s          = digit1 ? active[7:4] : active[3:0];
  assign frame_tick = (state == SHOW1) && (cnt == SHOW_TC);
  assign load_ready = ~pending;

  // A transfer needs pending=0 and a commit needs pending=1, so the two
  // can never happen on the same edge.
  assign transfer = load_valid && !pending;
  assign commit   = frame_tick && pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      cnt     <= '0;
      active  <= 8'h00;
      shadow  <= 8'h00;
      pending <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= at_tc ? '0 : cnt + CW'(1);
      if (commit) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (transfer) begin
        shadow  <= din;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 The block SHALL have parameter PERIOD, default 24000, meaning clock cycles each digit is lit; legal range >= 2.
REQ-002 The block SHALL have parameter DEAD, default 240, meaning blanking cycles before each digit; legal range 1 to PERIOD-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 The block SHALL have port load_valid, input, 1 bit: a new digit pair is offered on din.
REQ-006 The block SHALL have port load_ready, output, 1 bit: the shadow buffer can accept din.
REQ-007 The block SHALL have port din, input, 8 bits: [3:0] is the digit-0 nibble and [7:4] is the digit-1 nibble.
REQ-008 The block SHALL have port s, output, 4 bits: the nibble driven to the single shared seven-segment decoder.
REQ-009 The block SHALL have port an_n, output, 2 bits: active-low digit enables, where bit0 is digit 0 and bit1 is digit 1.
REQ-010 The block SHALL have port frame_tick, output, 1 bit: a one-cycle pulse at each frame boundary.

Function
REQ-011 The FSM SHALL have states BLANK0, SHOW0, BLANK1, SHOW1, cycling in that order.
REQ-012 A counter SHALL run from 0 to DEAD-1 in the BLANK states and from 0 to PERIOD-1 in the SHOW states; when it reaches its terminal value, it clears and the FSM advances.
REQ-013 The counter width SHALL be $clog2(PERIOD) bits; the counter SHALL never wrap past its terminal value.
REQ-014 an_n SHALL be 2'b10 in SHOW0, 2'b01 in SHOW1, and 2'b11 in both BLANK states.
REQ-015 s SHALL be the active digit-0 nibble in BLANK0/SHOW0 and the active digit-1 nibble in BLANK1/SHOW1, so the decoder settles during blanking.
REQ-016 an_n, s and frame_tick SHALL be decoded from registered state only, with no combinational path from din or load_valid.
REQ-017 frame_tick SHALL be 1 in the final cycle of SHOW1 (counter = PERIOD-1) and 0 otherwise.
REQ-018 Handshake: a transfer occurs when load_valid and load_ready are both high at a clock edge; on a transfer, din is written to the shadow register and the pending flag is set.
REQ-019 load_ready SHALL equal the inverse of the pending flag, so it deasserts in the cycle after a transfer.
REQ-020 Commit: at the frame-boundary edge (frame_tick high), if pending is set, the shadow register is copied to the active register and pending is cleared; the displayed value changes only at that boundary.
REQ-021 Simultaneous event: when a transfer and a frame boundary coincide, the transfer is possible only with pending=0; the new data goes to the shadow register and commits at the following boundary.
REQ-022 load_valid held high while load_ready is low SHALL be ignored, with no overwrite of pending data.

Reset
REQ-023 While reset is high at a clock edge, the block SHALL set: state BLANK0, counter 0, active register 8'h00, shadow register 8'h00, pending 0.
REQ-024 As a consequence, the cycle after reset SHALL show an_n=2'b11, s=4'h0, load_ready=1, frame_tick=0.
REQ-025 Reset mid-frame or with a pending load SHALL discard the pending data; reset has priority over a transfer in the same cycle.

Configuration
REQ-026 Macro SEVSEG_DEADTIME_EN: when defined, the BLANK states and the DEAD parameter SHALL be implemented as specified above.
REQ-027 When SEVSEG_DEADTIME_EN is undefined, the FSM SHALL be SHOW0 -> SHOW1 -> SHOW0, DEAD is unused, the reset state is SHOW0 (an_n=2'b10 after reset), and the frame is 2*PERIOD cycles.

Verification (PERIOD=8, DEAD=2)
REQ-028 Release reset with SEVSEG_DEADTIME_EN defined -> an_n sequence is 11 x2, 10 x8, 11 x2, 01 x8, repeating; frame_tick pulses every 20 cycles; s=0 throughout.
REQ-029 Load din=8'h3A at reset release -> s=4'h0 until the first frame_tick edge, then s=4'hA in BLANK0/SHOW0 and 4'h3 in BLANK1/SHOW1; load_ready is 0 from the cycle after the load until the cycle after that frame_tick.
REQ-030 Load 8'h12, then hold load_valid with din=8'h34 while load_ready=0 -> after the first boundary, 8'h12 is displayed and 8'h34 is then accepted; 8'h34 is displayed after the second boundary.
REQ-031 Transfer of 8'h5C in the same cycle as frame_tick with pending=0 -> the display is unchanged for that frame; 8'h5C is displayed after the next frame_tick.
REQ-032 Assert reset during SHOW1 with 8'h77 pending -> the next cycle shows an_n=2'b11, load_ready=1, and s=0; 8'h77 is never displayed.
REQ-033 SEVSEG_DEADTIME_EN undefined -> an_n alternates 10 x8, 01 x8; an_n is never 11 after reset; frame_tick pulses every 16 cycles.
